load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the CPU's execute stage (ALU result, rs2 data, control) and a variable-latency data bus.
//  Converts lb/lh/lw/lbu/lhu/sb/sh/sw into word-aligned bus transactions with byte enables.
//  Sign- or zero-extends load data and stalls the CPU (PC and register write held) until the access completes.
//  Detects misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles bus_req may wait for bus_ack before abort (1..65535)
//  CNT_W        16   width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  mem_read   in   1   load request from Control (level, held while stall=1)
//  mem_write  in   1   store request from Control (level, held while stall=1)
//  funct3     in   3   access type: 000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
//  addr       in   32  byte address (ALU result)
//  wdata      in   32  store data (rs2)
//  rdata      out  32  extended load data; valid in the DONE cycle
//  stall      out  1   1 = CPU must hold PC and suppress register write
//  misalign   out  1   one-cycle pulse: misaligned or illegal-funct3 access rejected
//  bus_err    out  1   one-cycle pulse: access aborted by timeout
//  bus_req    out  1   bus request, registered
//  bus_we     out  1   1 = write, registered
//  bus_addr   out  32  {addr[31:2],2'b00}, registered
//  bus_be     out  4   byte enables, registered
//  bus_wdata  out  32  store data replicated into lanes, registered
//  bus_rdata  in   32  read word; sampled when bus_ack=1
//  bus_ack    in   1   transaction complete, single-cycle pulse
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; counter 0. Mid-transaction reset drops bus_req immediately.
//  FSM states: IDLE, REQ, DONE.
//   IDLE: active = mem_read|mem_write. When active, stall=1 combinationally.
//    - If aligned and legal: register bus_* fields, set bus_req=1, go to REQ.
//    - If misaligned or illegal: misalign=1 and stall=0 this cycle; no bus activity; rdata=0; stay in IDLE.
//   REQ: bus_req held at 1 and stall=1, counter increments each cycle.
//    - bus_ack=1: capture the extended bus_rdata (loads only), clear bus_req, go to DONE.
//    - Counter reaches TIMEOUT_CYC without ack: clear bus_req, set rdata=0, pulse bus_err, go to DONE.
//   DONE: stall=0 for exactly one cycle; CPU retires the instruction; go to IDLE. No new request is accepted in DONE.
//  Alignment: h/hu requires addr[0]=0; w requires addr[1:0]=00; b/bu is always aligned.
//  Byte enables:
//   - b: 0001 << addr[1:0]
//   - h: 0011 << addr[1:0]
//   - w: 1111
//   - loads: bus_be set the same way; bus_we=0.
//  Store lanes:
//   - b: wdata[7:0] replicated to all 4 bytes
//   - h: wdata[15:0] replicated to both halves
//   - w: wdata as is
//  Load extract: select the byte/half at addr[1:0] from bus_rdata; b/h sign-extend, bu/hu zero-extend.
//  mem_read and mem_write both 1: treated as a store.
//  rdata holds its value outside DONE (cleared only by reset or by the next load/abort).
//  Minimum latency is 3 cycles (IDLE, REQ with same-cycle ack, DONE); the instruction completes in DONE.
//  bus_ack outside REQ is ignored. Counter clears on every entry to REQ.
// TESTING
//  T1 sw addr=0x100 wdata=0xDEADBEEF, ack after 2 cycles -> bus_be=1111, bus_we=1, stall high 3 cycles, then one DONE cycle
//  T2 lb addr=0x103, bus_rdata=0x80FF_0000 -> bus_be=1000, rdata=0xFFFFFF80; lbu on the same access -> rdata=0x00000080
//  T3 sh addr=0x202 wdata=0x0000ABCD -> bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD
//  T4 lw addr=0x101 -> misalign pulses 1 cycle, stall=0, bus_req never asserted
//  T5 lw with no ack, TIMEOUT_CYC=4 -> bus_req drops after 4 REQ cycles, bus_err pulse, rdata=0, DONE follows
//  T6 rst low during REQ -> bus_req=0 and stall=0 immediately; after release a new lhu at 0x002 (bus_rdata=0x8001_0000) -> rdata=0x00008001

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Bridges the CPU execute stage to a variable-latency, word-wide data bus.
//   Converts lb/lh/lw/lbu/lhu/sb/sh/sw into word-aligned bus transactions with
//   byte enables. Load data is sign- or zero-extended. The CPU is stalled until
//   the access completes. Misaligned or illegal accesses and bus timeouts are
//   reported as one-cycle pulses.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   mem_read   in   1   load request (level, held while stall=1)
//   mem_write  in   1   store request (level, held while stall=1); wins over mem_read
//   funct3     in   3   000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
//   addr       in   32  byte address
//   wdata      in   32  store data
//   rdata      out  32  extended load data, valid in the DONE cycle
//   stall      out  1   CPU must hold PC and suppress register write
//   misalign   out  1   access rejected (misaligned or illegal funct3)
//   bus_err    out  1   access aborted by timeout (high in the DONE cycle)
//   bus_req    out  1   bus request
//   bus_we     out  1   1 = write
//   bus_addr   out  32  word-aligned address
//   bus_be     out  4   byte enables
//   bus_wdata  out  32  store data replicated into byte lanes
//   bus_rdata  in   32  read word, sampled when bus_ack=1
//   bus_ack    in   1   transaction complete, single-cycle pulse
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               active, legal, aligned;
  logic               accept, reject, ack_hit, abort;
  logic [3:0]         be_c;
  logic [31:0]        lanes_c;

  // Captured request attributes needed when the read data returns
  logic [1:0]         off_p0;
  logic [2:0]         f3_p0;
  logic               load_p0;

  // Pick the addressed byte/half from the bus word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    shifted = word >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      3'b000:  begin ext_s = byte_s; load_extend = ext_s; end
      3'b001:  begin ext_s = half_s; load_extend = ext_s; end
      3'b100:  load_extend = {24'b0, shifted[7:0]};
      3'b101:  load_extend = {16'b0, shifted[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Request decode
  always_comb begin
    active  = mem_read | mem_write;
    legal   = 1'b0;
    aligned = 1'b0;
    be_c    = 4'b1111;
    lanes_c = wdata;
    case (funct3)
      3'b000, 3'b100: begin
        legal   = 1'b1;
        aligned = 1'b1;
        be_c    = 4'b0001 << addr[1:0];
        lanes_c = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        legal   = 1'b1;
        aligned = ~addr[0];
        be_c    = 4'b0011 << addr[1:0];
        lanes_c = {2{wdata[15:0]}};
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (addr[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // Next state and handshake outputs; everything quiet while reset is held
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    misalign  = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    ack_hit   = 1'b0;
    abort     = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (active) begin
            if (legal && aligned) begin
              stall     = 1'b1;
              accept    = 1'b1;
              state_nxt = REQ;
            end else begin
              misalign = 1'b1;
              reject   = 1'b1;
            end
          end
        end
        REQ: begin
          stall = 1'b1;
          if (bus_ack) begin
            ack_hit   = 1'b1;
            state_nxt = DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            abort     = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: bus request registers, counter, result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_err <= abort;
      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_c;
        bus_wdata <= lanes_c;
        cnt       <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
      if (ack_hit || abort) bus_req <= 1'b0;
      if (ack_hit && load_p0) rdata <= load_extend(bus_rdata, off_p0, f3_p0);
      if (abort || reject) rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      off_p0  <= addr[1:0];
      f3_p0   <= funct3;
      load_p0 <= ~mem_write;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = '0;

  load_store_unit #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access from the CPU side; expectations come from plain
  // arithmetic on the access description. ack_at = REQ cycle carrying the
  // ack (1-based), 0 = never acknowledge.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int ack_at);
    int          nbytes, off, n, exp_n;
    bit          legal, ok, is_store, timeout, done;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    longint      v, wv;

    is_store = wr;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
    off = int'(a % 4);
    ok = legal && ((int'(a % 4) % nbytes) == 0);
    e_be = 4'(((1 << nbytes) - 1) << off);
    for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = wd[8*(k % nbytes) +: 8];
    timeout = (ack_at < 1 || ack_at > TO);
    exp_n = timeout ? TO : ack_at;

    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    check("idle_stall", {31'b0, stall}, {31'b0, ok});
    check("idle_misalign", {31'b0, misalign}, {31'b0, !ok});
    if (!ok) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      exp_rdata = '0;
      #1;
      check("rej_bus_req", {31'b0, bus_req}, 32'd0);
      check("rej_rdata", rdata, exp_rdata);
      check("rej_misalign_gone", {31'b0, misalign}, 32'd0);
      return;
    end

    @(negedge clk);
    #1;
    check("req_bus_req", {31'b0, bus_req}, 32'd1);
    check("req_stall", {31'b0, stall}, 32'd1);
    check("req_we", {31'b0, bus_we}, {31'b0, is_store});
    check("req_addr", bus_addr, a & 32'hFFFF_FFFC);
    check("req_be", {28'b0, bus_be}, {28'b0, e_be});
    if (is_store) check("req_wdata", bus_wdata, e_wd);

    n = 1; done = 0;
    while (!done) begin
      if (n == ack_at) begin bus_ack = 1'b1; bus_rdata = rword; end
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      #1;
      if (!bus_req) done = 1;
      else begin
        check("req_stall_hold", {31'b0, stall}, 32'd1);
        n++;
        if (n > TO + 2) begin
          check("req_never_ends", {31'b0, bus_req}, 32'd0);
          done = 1;
        end
      end
    end
    check("req_cycles", n, exp_n);

    if (timeout) exp_rdata = '0;
    else if (!is_store) begin
      wv = longint'(rword);
      v = (wv >> (8 * off)) & ((64'sd1 <<< (8 * nbytes)) - 1);
      if (f3 < 3'd4 && nbytes < 4 && v >= (64'sd1 <<< (8 * nbytes - 1)))
        v = v - (64'sd1 <<< (8 * nbytes));
      exp_rdata = v[31:0];
    end
    check("done_stall", {31'b0, stall}, 32'd0);
    check("done_bus_err", {31'b0, bus_err}, {31'b0, timeout});
    check("done_rdata", rdata, exp_rdata);

    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check("after_bus_err", {31'b0, bus_err}, 32'd0);
    check("after_stall", {31'b0, stall}, 32'd0);
    check("after_bus_req", {31'b0, bus_req}, 32'd0);
    check("after_rdata_hold", rdata, exp_rdata);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] bad_f3 [3];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    bad_f3[0] = 3'd3; bad_f3[1] = 3'd6; bad_f3[2] = 3'd7;

    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", {28'b0, bus_be}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_flags", {29'b0, misalign, bus_err, bus_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // T1 sw, ack in second REQ cycle
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    // T2 lb / lbu at top byte
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
    check("t2_lb", rdata, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 3);
    check("t2_lbu", rdata, 32'h0000_0080);
    // T3 sh upper half
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1);
    // T4 misaligned lw
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    // T5 lw with no ack: timeout
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 0);
    check("t5_rdata", rdata, 32'd0);
    // Load followed by ack on the last allowed cycle
    do_access(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 32'hFEDC_1234, TO);
    // Both read and write: store
    do_access(1'b1, 1'b1, 3'b000, 32'h401, 32'h0000_005A, 32'hFFFF_FFFF, 1);

    // Stray ack while idle must be ignored
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("idle_ack_req", {31'b0, bus_req}, 32'd0);
    check("idle_ack_rdata", rdata, exp_rdata);

    // T6 reset during REQ
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    #1;
    check("t6_in_req", {31'b0, bus_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_req_drop", {31'b0, bus_req}, 32'd0);
    check("t6_stall_drop", {31'b0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    mem_read = 1'b0; rst = 1'b1; exp_rdata = '0;
    #1;
    check("t6_rdata_rst", rdata, 32'd0);
    do_access(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 32'h8001_0000, 2);
    check("t6_lhu", rdata, 32'h0000_8001);

    // Randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      logic        r, w;
      logic [2:0]  f;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) begin r = 1'b1; w = 1'b0; f = ld_f3[$urandom_range(0, 4)]; end
      else if (sel < 9) begin r = sel[0]; w = 1'b1; f = 3'($urandom_range(0, 2)); end
      else begin r = 1'b1; w = 1'b0; f = bad_f3[$urandom_range(0, 2)]; end
      do_access(r, w, f, $urandom, $urandom, $urandom, int'($urandom_range(0, TO)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
